cfu_job_initiator: RTL
======================

# cfu_job_initiator

Hardware initiator for the CFU command/response protocol. It drives the same `cmd_*`/`rsp_*` handshake the CPU normally drives, letting a fabric-side engine run a complete conv1d job without CPU involvement. Each job streams input and filter bytes from a local byte memory into the CFU buffers, programs the parameters, starts computation, polls for completion and returns the accumulator.

## Interface
Parameters:
- `BUF_BYTES`, 1024: CFU buffer size in bytes (kernel length 8 × 128 channels).
- `POLL_LIMIT`, 65535: maximum number of status polls before the job is declared timed out.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `job_valid`  in  1  job request.
- `job_ready`  out  1  high when idle.
- `job_len`  in  11  byte count per buffer; bits [2:0] are ignored; depth = `job_len>>3`.
- `job_input_offset`  in  32  signed offset, sent as command 3.
- `src_rd_en`  out  1  source memory read strobe.
- `src_addr`  out  11  source byte address.
  - Input bytes live at 0..1023.
  - Filter bytes live at 1024 + i.
  - The address is therefore {sel, idx}, 1+10 bits; the port is 11 bits.
- `src_rd_data`  in  8  valid 1 cycle after `src_rd_en`.
- `cmd_valid`  out  1  CFU command valid.
- `cmd_ready`  in  1  CFU command ready.
- `cmd_payload_function_id`  out  10  {funct7, 3'b000}.
- `cmd_payload_inputs_0`  out  32  address.
- `cmd_payload_inputs_1`  out  32  value.
- `rsp_valid`  in  1  CFU response valid.
- `rsp_ready`  out  1  response accept.
- `rsp_payload_outputs_0`  in  32  CFU response data.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  result consumed.
- `result_acc`  out  32  final accumulator.
- `result_timeout`  out  1  job ended by poll timeout.

## Operation
- Exactly one command is outstanding at a time.
  - A command is issued, then the initiator waits for its response before the next.
  - Every response is consumed, including the responses to writes.
- Funct7 map:
  - 1: write input byte.
  - 2: write filter byte.
  - 3: input offset.
  - 5: input depth.
  - 6: start.
  - 9: status (bit 0 = done).
  - 7: read accumulator.
- FSM states and transitions:
  - IDLE → LOAD_IN on `job_valid && job_ready`; the job fields are latched.
  - LOAD_IN issues 8·depth commands: funct7=1, inputs_0=i, inputs_1={24'sign-ext, byte}.
  - LOAD_IN → LOAD_FLT: same as LOAD_IN but funct7=2, with the byte read from 1024+i.
  - LOAD_FLT → SET_OFS: funct7=3, inputs_1=offset.
  - SET_OFS → SET_DEPTH: funct7=5, inputs_1=depth.
  - SET_DEPTH → START: funct7=6.
  - START → POLL: funct7=9.
    - If response bit0=0 and polls < `POLL_LIMIT`, reissue the poll.
    - If bit0=1, go to READ_ACC.
    - If the limit is reached, go to DONE with acc=0 and timeout=1.
  - READ_ACC: funct7=7; the response is stored to `result_acc`; then go to DONE.
  - DONE holds `result_*` until `result_ready`, then returns to IDLE.
- Per-command sub-phases in the load states: FETCH (`src_rd_en`), CAPTURE (data is registered into the payload), ISSUE, WAIT_RSP.
- depth=0: IDLE → DONE directly, with no CFU or source traffic; acc=0, timeout=0.
- Unused payload fields are 0. `inputs_0` is zero-extended.

## Timing
- Reset values: all outputs 0, except `job_ready`=1.
- Reset mid-job:
  - The FSM returns to IDLE on the next edge and any outstanding command is abandoned.
  - The system must reset the CFU together with this block.
- `cmd_valid`, once high, holds and its payload stays stable until a cycle with `cmd_ready`=1. It drops on the following cycle.
- `rsp_ready`=1 only in WAIT_RSP. A response arriving at any other time is ignored.
- The next FETCH or ISSUE starts the cycle after the response handshake.
- With a zero-wait responder, each load command costs 4 cycles and each parameter or poll command costs 2.
- `job_ready` deasserts the cycle after acceptance.
- `result_valid` rises the cycle after the READ_ACC handshake, or on the timeout decision.
- The poll counter is 16 bits and saturates.

## Structure
- Package `cfu_cmd_pkg`:
  - funct7 localparams: CFU_WR_INPUT, CFU_WR_FILTER, CFU_SET_OFFSET, CFU_SET_DEPTH, CFU_START, CFU_READ_ACC, CFU_STATUS.
  - KERNEL_LENGTH=8.
  - The state enum `job_state_t`.
- Sub-module `cfu_cmd_port`: single-outstanding issue/response handshake.
  - Accepts a command and payload on req_valid/req_ready.
  - Returns the response data on a done pulse.
  - The job FSM sits on top of it.

## Test plan
- **Basic job:** len=8, input 1..8, filter all 1, offset 0, responder done on first poll, acc=36.
  - The command trace is exactly 8×f1, 8×f2, f3, f5, f6, f9, f7 (21 commands).
  - `result_acc`=36 and `result_timeout`=0.
- **Backpressure:** random `cmd_ready` and delayed `rsp_valid`.
  - The payload stays stable while waiting.
  - No second command is issued before its response.
  - The trace is identical to the basic job.
- **Polling:** status responses 0, 0, 0, 1 → exactly 4 f9 commands, then f7.
- **Timeout:** POLL_LIMIT=4, status never done → 4 polls, no f7, `result_timeout`=1, acc=0.
- **Reset mid-LOAD_FLT:** all outputs are at reset values after one edge; a following len=16 job completes correctly.
- **Edge lengths:**
  - len=0 → `result_valid` with no `cmd_valid` ever.
  - len=1024 → the last f1 has inputs_0=1023, the last `src_addr` is 2047, and depth=128.

Source files
------------

// File: rtl/cfu_cmd_pkg.sv
// cfu_cmd_pkg: CFU command codes, kernel geometry and job FSM encodings
package cfu_cmd_pkg;
  localparam logic [6:0] CFU_WR_INPUT   = 7'd1;
  localparam logic [6:0] CFU_WR_FILTER  = 7'd2;
  localparam logic [6:0] CFU_SET_OFFSET = 7'd3;
  localparam logic [6:0] CFU_SET_DEPTH  = 7'd5;
  localparam logic [6:0] CFU_START      = 7'd6;
  localparam logic [6:0] CFU_READ_ACC   = 7'd7;
  localparam logic [6:0] CFU_STATUS     = 7'd9;
  localparam int KERNEL_LENGTH = 8;
  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD_IN, ST_LOAD_FLT, ST_SET_OFS, ST_SET_DEPTH,
    ST_START, ST_POLL, ST_READ_ACC, ST_DONE
  } job_state_t;
  typedef enum logic [1:0] {PH_FETCH, PH_CAPTURE, PH_CMD} load_phase_t;
  function automatic logic [9:0] fid(input logic [6:0] f7);
    return {f7, 3'b000};
  endfunction
endpackage

// File: rtl/cfu_cmd_port.sv
// cfu_cmd_port: single-outstanding CFU command issue and response collection
module cfu_cmd_port (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [9:0]  req_function_id,
  input  logic [31:0] req_inputs_0,
  input  logic [31:0] req_inputs_1,
  output logic        done,
  output logic [31:0] done_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0
);
  logic busy;
  // requester holds the payload steady until done, so it passes straight through
  assign cmd_valid = req_valid && !busy;
  assign cmd_payload_function_id = req_function_id;
  assign cmd_payload_inputs_0 = req_inputs_0;
  assign cmd_payload_inputs_1 = req_inputs_1;
  assign rsp_ready = busy;
  assign done = busy && rsp_valid;
  assign done_data = rsp_payload_outputs_0;
  always_ff @(posedge clk)
    if (!reset_n) busy <= 1'b0;
    else if (cmd_valid && cmd_ready) busy <= 1'b1;
    else if (done) busy <= 1'b0;
endmodule

// File: rtl/cfu_job_initiator.sv
// cfu_job_initiator: runs a full conv1d job on the CFU from a local byte memory
module cfu_job_initiator
  import cfu_cmd_pkg::*;
#(
  parameter int BUF_BYTES  = 1024,
  parameter int POLL_LIMIT = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [10:0] job_len,
  input  logic [31:0] job_input_offset,
  output logic        src_rd_en,
  output logic [10:0] src_addr,
  input  logic [7:0]  src_rd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_acc,
  output logic        result_timeout
);
  job_state_t state;
  load_phase_t ph;
  logic [9:0] idx;
  logic [7:0] depth, job_depth, byte_q;
  logic [31:0] ofs, in0, in1, done_data;
  logic [15:0] polls, polls_n;
  logic [6:0] f7;
  logic loading, last, req_valid, done;
  assign job_depth = 8'(job_len / 11'(KERNEL_LENGTH));
  assign loading = state == ST_LOAD_IN || state == ST_LOAD_FLT;
  assign last = {1'b0, idx} == 11'(depth * KERNEL_LENGTH - 1);
  assign polls_n = &polls ? polls : polls + 16'd1;
  assign req_valid = loading ? ph == PH_CMD : !(state inside {ST_IDLE, ST_DONE});
  assign job_ready = state == ST_IDLE;
  assign result_valid = state == ST_DONE;
  assign src_rd_en = loading && ph == PH_FETCH;
  assign src_addr = !src_rd_en ? 11'd0 : state == ST_LOAD_FLT ? 11'(BUF_BYTES) + 11'(idx) : 11'(idx);
  assign f7 = state == ST_LOAD_IN   ? CFU_WR_INPUT   :
              state == ST_LOAD_FLT  ? CFU_WR_FILTER  :
              state == ST_SET_OFS   ? CFU_SET_OFFSET :
              state == ST_SET_DEPTH ? CFU_SET_DEPTH  :
              state == ST_START     ? CFU_START      :
              state == ST_POLL      ? CFU_STATUS     :
              state == ST_READ_ACC  ? CFU_READ_ACC   : 7'd0;
  assign in0 = loading ? {22'd0, idx} : 32'd0;
  assign in1 = loading ? {{24{byte_q[7]}}, byte_q} :
               state == ST_SET_OFS ? ofs :
               state == ST_SET_DEPTH ? {24'd0, depth} : 32'd0;
  cfu_cmd_port port (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_function_id(fid(f7)),
    .req_inputs_0(in0),
    .req_inputs_1(in1),
    .done(done),
    .done_data(done_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0),
    .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_payload_outputs_0)
  );
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= ST_IDLE;
      ph <= PH_FETCH;
      idx <= '0;
      depth <= '0;
      ofs <= '0;
      byte_q <= '0;
      polls <= '0;
      result_acc <= '0;
      result_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (job_valid) begin
          depth <= job_depth;
          ofs <= job_input_offset;
          idx <= '0;
          ph <= PH_FETCH;
          polls <= '0;
          result_acc <= '0;
          result_timeout <= 1'b0;
          state <= job_depth == 8'd0 ? ST_DONE : ST_LOAD_IN;
        end
        ST_LOAD_IN, ST_LOAD_FLT:
          if (ph == PH_FETCH) ph <= PH_CAPTURE;
          else if (ph == PH_CAPTURE) begin
            byte_q <= src_rd_data;
            ph <= PH_CMD;
          end else if (done) begin
            ph <= PH_FETCH;
            idx <= last ? '0 : idx + 10'd1;
            if (last) state <= state == ST_LOAD_IN ? ST_LOAD_FLT : ST_SET_OFS;
          end
        ST_SET_OFS: if (done) state <= ST_SET_DEPTH;
        ST_SET_DEPTH: if (done) state <= ST_START;
        ST_START: if (done) state <= ST_POLL;
        ST_POLL: if (done) begin
          polls <= polls_n;
          if (done_data[0]) state <= ST_READ_ACC;
          else if (polls_n >= 16'(POLL_LIMIT)) begin
            state <= ST_DONE;
            result_timeout <= 1'b1;
          end
        end
        ST_READ_ACC: if (done) begin
          result_acc <= done_data;
          state <= ST_DONE;
        end
        ST_DONE: if (result_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
endmodule
